if_stage: RTL and testbench
===========================

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 20: instruction ROM word-address width.
REQ-002 SHALL have parameter RESET_PC, default 32'h1C00_0000: first fetch address after reset.
REQ-003 SHALL have port clk, input, 1: the single clock; all state on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port rom_addr, output, ADDR_BITS: word address to the combinational instruction ROM.
REQ-006 SHALL have port rom_data, input, 32: instruction word returned in the same cycle.
REQ-007 SHALL have ports redirect_valid (input, 1) and redirect_pc (input, 32): branch/exception target from execute.
REQ-008 SHALL have ports id_valid (output, 1), id_ready (input, 1), id_inst (output, 32) and id_pc (output, 32): valid/ready handshake to decode.
REQ-009 SHALL have port id_exc_adef, output, 1: fetch-address-error flag travelling with id_inst.

Function
REQ-010 SHALL hold a 32-bit PC register and drive rom_addr = pc[ADDR_BITS+1:2] combinationally.
REQ-011 SHALL buffer fetched {pc, inst, adef} entries in a 2-entry FIFO with 2-bit occupancy count 0..2.
REQ-012 SHALL push {pc, rom_data} and advance pc by 4 (mod 2^32) when push_ok and not redirect_valid.
- push_ok = count<2 OR a pop occurs in the same cycle.
REQ-013 SHALL drive id_valid = (count!=0), with id_inst/id_pc/id_exc_adef taken from the FIFO head.
REQ-014 SHALL pop the head on a cycle where id_valid and id_ready are both 1.
- Simultaneous push and pop leaves count unchanged.
REQ-015 SHALL hold id_* outputs stable while id_valid=1 and id_ready=0.
REQ-016 SHALL, on redirect_valid=1, take priority over everything else:
- FIFO flushed (count=0), pc <= redirect_pc, no push that cycle.
- Any pending pop is discarded.
REQ-017 SHALL present a fetched instruction on id_* exactly one cycle after its address is on rom_addr (fetch-to-decode latency 1).
REQ-018 SHALL sustain one instruction per cycle while id_ready=1 and no redirect.
REQ-019 SHALL, while count=2 and no pop occurs, hold pc and not push.

Reset
REQ-020 SHALL, while rst_n=0 (asynchronously), hold pc=RESET_PC, count=0, FIFO pointers=0, id_valid=0, id_exc_adef=0.
REQ-021 SHALL push the RESET_PC fetch on the first rising clk edge after rst_n deasserts; id_valid=1 from that edge.
REQ-022 SHALL, on reset asserted mid-stream, discard all buffered entries without presenting them.

Configuration
REQ-023 SHALL implement misaligned-fetch detection only when macro IF_ADEF_EN is defined.
REQ-024 SHALL, with IF_ADEF_EN defined:
- A redirect to pc[1:0]!=0 makes the next push carry adef=1 with rom_data ignored (id_inst=0).
- Fetch then halts (no further pushes) until the next redirect_valid.
REQ-025 SHALL, without IF_ADEF_EN:
- Force redirect_pc[1:0] to 2'b00.
- Tie id_exc_adef to 0.
- Never halt.

Structure
REQ-026 SHALL place RESET_PC default, instruction width (32) and FIFO depth (2) constants in the shared core package.
REQ-027 SHALL implement the buffer as one sub-module if_fifo (2-entry, synchronous push/pop/flush, async active-low reset).

Verification
REQ-028 SHALL check reset release with id_ready=1: id_pc = 1C000000, 1C000004, 1C000008 on consecutive cycles; rom_addr = 0, 1, 2.
REQ-029 SHALL check id_ready=0 for 5 cycles after reset: count saturates at 2, pc=1C000008, id_pc holds 1C000000; releasing id_ready yields 1C000000, 1C000004, 1C000008 with no gap.
REQ-030 SHALL check redirect_valid=1, redirect_pc=1C000100 while FIFO full: next cycle id_valid=0; following cycle id_pc=1C000100.
REQ-031 SHALL check redirect in the same cycle as a handshake: popped entry is dropped, only 1C000100 onward appears.
REQ-032 SHALL check, with IF_ADEF_EN, redirect_pc=1C000102: one entry with id_exc_adef=1, id_pc=1C000102, then id_valid=0 until a redirect to 1C000200 resumes fetch.
REQ-033 SHALL check pc wrap via redirect_pc=FFFFFFFC: next fetched id_pc=00000000.

Source files
------------

// File: rtl/if_stage_pkg.sv
// -----------------------------------------------------------------------------
// if_stage_pkg
// Shared constants and types for the instruction-fetch stage.
//   RESET_PC_DEFAULT : default first fetch address after reset
//   INST_W           : instruction word width
//   FIFO_DEPTH       : fetch buffer depth (entries)
//   COUNT_W          : width of the buffer occupancy count (0..FIFO_DEPTH)
//   fetch_entry_t    : one buffered fetch {pc, inst, adef}
//   fetch_state_t    : fetch run/halt state (halt only used with IF_ADEF_EN)
// -----------------------------------------------------------------------------
package if_stage_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h1C00_0000;
    localparam int          INST_W           = 32;
    localparam int          FIFO_DEPTH       = 2;
    localparam int          COUNT_W          = 2;
    localparam int          PTR_W            = $clog2(FIFO_DEPTH);

    typedef struct packed {
        logic [31:0]       pc;
        logic [INST_W-1:0] inst;
        logic              adef;
    } fetch_entry_t;

    typedef enum logic {
        FETCH_RUN  = 1'b0,
        FETCH_HALT = 1'b1
    } fetch_state_t;

    // A fetch address is misaligned when it is not on a 4-byte boundary.
    function automatic logic is_misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/if_stage_fifo.sv
// -----------------------------------------------------------------------------
// if_fifo
// Two-entry fetch buffer with synchronous push/pop/flush and asynchronous
// active-low reset. Flush wins over push and pop in the same cycle.
// Ports:
//   clk, rst_n    : clock, async active-low reset
//   flush         : empty the buffer (count and pointers to 0)
//   push          : write push_entry at the tail
//   push_entry    : entry to write
//   pop           : discard the head entry
//   head_entry    : current head (valid when count != 0)
//   count         : occupancy 0..FIFO_DEPTH
// -----------------------------------------------------------------------------
module if_fifo
    import if_stage_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               push,
    input  fetch_entry_t       push_entry,
    input  logic               pop,
    output fetch_entry_t       head_entry,
    output logic [COUNT_W-1:0] count
);

    logic [PTR_W-1:0]   wr_ptr_reg;
    logic [PTR_W-1:0]   rd_ptr_reg;
    logic [COUNT_W-1:0] count_reg;
    logic               do_push;
    logic               do_pop;

    fetch_entry_t [FIFO_DEPTH-1:0] slot_q;

    // Guard against overflow/underflow even if the caller misbehaves; a pop
    // on a full buffer frees the slot the simultaneous push writes into.
    assign do_pop  = pop  && !flush && (count_reg != '0);
    assign do_push = push && !flush &&
                     ((count_reg != COUNT_W'(FIFO_DEPTH)) || do_pop);

    generate
        for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_slot
            fetch_entry_t slot_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    slot_reg <= '0;
                end else if (do_push && (wr_ptr_reg == PTR_W'(gi))) begin
                    slot_reg <= push_entry;
                end
            end

            assign slot_q[gi] = slot_reg;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign head_entry = slot_q[rd_ptr_reg];
    assign count      = count_reg;

endmodule

// File: rtl/if_stage.sv
// -----------------------------------------------------------------------------
// if_stage
// Instruction fetch stage: a PC register addresses a combinational ROM, the
// returned word is buffered with its PC in a 2-entry FIFO and handed to decode
// over a valid/ready handshake. A redirect from execute flushes the buffer and
// reloads the PC.
//
// Optional feature (macro IF_ADEF_EN): misaligned-fetch detection. A redirect
// to a non-word-aligned address produces one entry flagged id_exc_adef=1 with
// id_inst=0, after which fetch halts until the next redirect. Without the
// macro, redirect targets are forced word-aligned and fetch never halts.
//
// Parameters:
//   ADDR_BITS : ROM word-address width
//   RESET_PC  : first fetch address after reset
// Ports:
//   clk, rst_n      : clock, async active-low reset
//   rom_addr        : ROM word address (pc[ADDR_BITS+1:2])
//   rom_data        : ROM instruction word, same cycle
//   redirect_valid  : load redirect_pc and flush the buffer
//   redirect_pc     : redirect target
//   id_valid/ready  : handshake to decode
//   id_inst, id_pc  : head instruction and its address
//   id_exc_adef     : fetch address error flag for the head entry
// -----------------------------------------------------------------------------
module if_stage
    import if_stage_pkg::*;
#(
    parameter int          ADDR_BITS = 20,
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    output logic [ADDR_BITS-1:0] rom_addr,
    input  logic [INST_W-1:0]    rom_data,
    input  logic                 redirect_valid,
    input  logic [31:0]          redirect_pc,
    output logic                 id_valid,
    input  logic                 id_ready,
    output logic [INST_W-1:0]    id_inst,
    output logic [31:0]          id_pc,
    output logic                 id_exc_adef
);

    logic [31:0]        pc_reg;
    logic [31:0]        pc_next;
    fetch_state_t       state_reg;
    fetch_state_t       state_next;

    logic [COUNT_W-1:0] count;
    fetch_entry_t       head_entry;
    fetch_entry_t       push_entry;
    logic               handshake;
    logic               push_ok;
    logic               push;
    logic               pop;
    logic               fetch_adef;
    logic [31:0]        redirect_target;

`ifdef IF_ADEF_EN
    assign fetch_adef      = is_misaligned(pc_reg);
    assign redirect_target = redirect_pc;
`else
    assign fetch_adef      = 1'b0;
    assign redirect_target = redirect_pc & 32'hFFFF_FFFC;
`endif

    assign rom_addr  = pc_reg[ADDR_BITS+1:2];

    assign id_valid  = (count != '0);
    assign handshake = id_valid && id_ready;

    // A handshake frees a slot in the same cycle, so a full buffer can still
    // accept the next fetch and sustain one instruction per cycle.
    assign push_ok   = (count < COUNT_W'(FIFO_DEPTH)) || handshake;

    // Redirect dominates: the popped entry is discarded and nothing is pushed.
    assign pop       = handshake && !redirect_valid;
    assign push      = push_ok && !redirect_valid && (state_reg == FETCH_RUN);

    // On an address error the ROM word is meaningless, so it is replaced by 0.
    assign push_entry.pc   = pc_reg;
    assign push_entry.inst = fetch_adef ? '0 : rom_data;
    assign push_entry.adef = fetch_adef;

    always_comb begin
        pc_next    = pc_reg;
        state_next = state_reg;
        if (redirect_valid) begin
            pc_next    = redirect_target;
            state_next = FETCH_RUN;
        end else if (push) begin
            if (fetch_adef) begin
                // The faulting entry is the last one until a redirect arrives.
                state_next = FETCH_HALT;
            end else begin
                pc_next = pc_reg + 32'd4;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_reg    <= RESET_PC;
            state_reg <= FETCH_RUN;
        end else begin
            pc_reg    <= pc_next;
            state_reg <= state_next;
        end
    end

    if_fifo u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (redirect_valid),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .head_entry (head_entry),
        .count      (count)
    );

    assign id_inst     = head_entry.inst;
    assign id_pc       = head_entry.pc;
    // Without IF_ADEF_EN the stored flag is only ever written 0, so this
    // reduces to a constant 0; gating with id_valid keeps it 0 when empty.
    assign id_exc_adef = id_valid && head_entry.adef;

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [19:0] rom_addr;
    logic [31:0] rom_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
    logic        id_exc_adef;

    always #5 clk = ~clk;

    if_stage dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .rom_addr       (rom_addr),
        .rom_data       (rom_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_inst        (id_inst),
        .id_pc          (id_pc),
        .id_exc_adef    (id_exc_adef)
    );

    // Combinational ROM contents: a simple function of the word address.
    function automatic logic [31:0] rom_fn(input logic [19:0] a);
        return {a[15:0] ^ 16'h1234, a[19:4]} ^ 32'hA5A5_0000;
    endfunction

    assign rom_data = rom_fn(rom_addr);

`ifdef IF_ADEF_EN
    localparam bit ADEF_EN = 1'b1;
`else
    localparam bit ADEF_EN = 1'b0;
`endif

    // Behavioural model: a queue of what decode must see, plus the fetch PC.
    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        adef;
    } ent_t;

    ent_t        q[$];
    logic [31:0] mpc;
    bit          mhalt;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        mpc   = 32'h1C00_0000;
        mhalt = 1'b0;
    endtask

    // One rising edge of the specified behaviour.
    task automatic model_step();
        ent_t e;
        bit   had = (q.size() != 0);
        if (redirect_valid) begin
            q.delete();
            mpc   = ADEF_EN ? redirect_pc : (redirect_pc & 32'hFFFF_FFFC);
            mhalt = 1'b0;
        end else begin
            if (had && id_ready) void'(q.pop_front());
            if (!mhalt && q.size() < 2) begin
                e.pc   = mpc;
                e.adef = (mpc[1:0] != 2'b00);
                e.inst = e.adef ? 32'h0 : rom_fn(mpc[21:2]);
                q.push_back(e);
                if (e.adef) mhalt = 1'b1;
                else        mpc   = mpc + 32'd4;
            end
        end
    endtask

    task automatic compare_all();
        chk("id_valid", id_valid, q.size() != 0);
        chk("rom_addr", rom_addr, mpc[21:2]);
        if (q.size() != 0) begin
            chk("id_pc", id_pc, q[0].pc);
            chk("id_inst", id_inst, q[0].inst);
            chk("id_exc_adef", id_exc_adef, q[0].adef);
        end else begin
            chk("id_exc_adef_idle", id_exc_adef, 1'b0);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        if (rst_n) model_step();
        #1;
        compare_all();
        $display("t=%0t valid=%0b ready=%0b redir=%0b pc=%h inst=%h adef=%0b rom_addr=%h",
                 $time, id_valid, id_ready, redirect_valid, id_pc, id_inst, id_exc_adef, rom_addr);
    endtask

    // Assert reset asynchronously, check the reset state, release after an edge.
    task automatic hard_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_valid", id_valid, 1'b0);
        chk("rst_adef", id_exc_adef, 1'b0);
        chk("rst_rom_addr", rom_addr, 20'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n          = 1'b0;
        id_ready       = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        model_reset();

        // Reset release, streaming
        hard_reset();
        chk("t1_rom_addr0", rom_addr, 20'h0);
        cycle(); chk("t1_pc0", id_pc, 32'h1C00_0000); chk("t1_ra1", rom_addr, 20'h1);
        cycle(); chk("t1_pc1", id_pc, 32'h1C00_0004); chk("t1_ra2", rom_addr, 20'h2);
        cycle(); chk("t1_pc2", id_pc, 32'h1C00_0008);

        // Backpressure after reset: buffer saturates, head holds
        id_ready = 1'b0;
        hard_reset();
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("t2_hold", id_pc, 32'h1C00_0000);
        end
        chk("t2_ra_pc08", rom_addr, 20'h2);
        chk("t2_model_count", q.size(), 2);
        id_ready = 1'b1;
        chk("t2_r0", id_pc, 32'h1C00_0000);
        cycle(); chk("t2_r1", id_pc, 32'h1C00_0004); chk("t2_r1v", id_valid, 1'b1);
        cycle(); chk("t2_r2", id_pc, 32'h1C00_0008); chk("t2_r2v", id_valid, 1'b1);

        // Redirect while full
        id_ready = 1'b0;
        cycle(); cycle(); cycle();
        chk("t3_model_full", q.size(), 2);
        redirect_valid = 1'b1; redirect_pc = 32'h1C00_0100;
        cycle();
        redirect_valid = 1'b0;
        chk("t3_flushed", id_valid, 1'b0);
        cycle(); chk("t3_pc", id_pc, 32'h1C00_0100);

        // Redirect on a handshake cycle drops the popped entry
        id_ready = 1'b1;
        cycle(); cycle();
        chk("t4_pre_pc", id_pc, 32'h1C00_0108);
        redirect_valid = 1'b1; redirect_pc = 32'h1C00_0100;
        cycle();
        redirect_valid = 1'b0;
        chk("t4_flushed", id_valid, 1'b0);
        cycle(); chk("t4_pc0", id_pc, 32'h1C00_0100);
        cycle(); chk("t4_pc1", id_pc, 32'h1C00_0104);

        // Misaligned redirect
        id_ready = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'h1C00_0102;
        cycle();
        redirect_valid = 1'b0;
        cycle();
`ifdef IF_ADEF_EN
        chk("t5_pc", id_pc, 32'h1C00_0102);
        chk("t5_adef", id_exc_adef, 1'b1);
        chk("t5_inst", id_inst, 32'h0);
        id_ready = 1'b1;
        cycle(); chk("t5_halt0", id_valid, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle(); chk("t5_halt", id_valid, 1'b0);
        end
        redirect_valid = 1'b1; redirect_pc = 32'h1C00_0200;
        cycle();
        redirect_valid = 1'b0;
        cycle(); chk("t5_resume", id_pc, 32'h1C00_0200);
        chk("t5_resume_adef", id_exc_adef, 1'b0);
`else
        chk("t5_pc_aligned", id_pc, 32'h1C00_0100);
        chk("t5_no_adef", id_exc_adef, 1'b0);
        id_ready = 1'b1;
        cycle(); chk("t5_next", id_pc, 32'h1C00_0104);
`endif

        // PC wrap
        id_ready = 1'b1;
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        cycle();
        redirect_valid = 1'b0;
        chk("t6_ra_top", rom_addr, 20'hFFFFF);
        cycle(); chk("t6_pc_top", id_pc, 32'hFFFF_FFFC);
        cycle(); chk("t6_pc_wrap", id_pc, 32'h0000_0000);

        // Mixed ready pattern with occasional redirects, model-checked
        for (int i = 0; i < 48; i++) begin
            logic [15:0] pat;
            pat = 16'b1011_0010_1110_0101;
            id_ready       = pat[i % 16];
            redirect_valid = ((i % 13) == 7);
            redirect_pc    = 32'h1C00_0400 + 32'(i * 8);
            cycle();
        end
        redirect_valid = 1'b0;

        // Reset mid-stream discards buffered entries
        id_ready = 1'b0;
        cycle(); cycle();
        hard_reset();
        chk("t8_after_rst_valid", id_valid, 1'b0);
        id_ready = 1'b1;
        cycle(); chk("t8_pc0", id_pc, 32'h1C00_0000);
        cycle(); chk("t8_pc1", id_pc, 32'h1C00_0004);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
